// File: rtl/gcd_fifo_sequencer.sv
// Read-side sequencer between the operand FIFO and the GCD engine.
// Pops A/B pairs, runs the engine (or bypasses on a zero operand) and hands off the result.
module gcd_fifo_sequencer #(
  parameter int DATA_WIDTH = 4,
  parameter int TIMEOUT    = 64,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_rd_en_o,
  output logic                  gcd_start_o,
  output logic [DATA_WIDTH-1:0] gcd_a_o,
  output logic [DATA_WIDTH-1:0] gcd_b_o,
  input  logic                  gcd_done_i,
  input  logic [DATA_WIDTH-1:0] gcd_result_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [DATA_WIDTH-1:0] res_data_o,
  output logic                  timeout_o,
  output logic [CNT_WIDTH-1:0]  pair_cnt_o
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, RD_A, CAP_A, RD_B, CAP_B, START, WAIT, OUT
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic [TW-1:0]         tmo_cnt;
  logic                  tmo_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  bypass;
  logic                  tmo_hit;

  // gcd(x,0)=x and gcd(0,0)=0, so a zero operand never needs the engine
  assign bypass  = (a_q == '0) || (fifo_data_i == '0);
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

  assign gcd_a_o    = a_q;
  assign gcd_b_o    = b_q;
  assign res_data_o = res_q;
  assign timeout_o  = tmo_q;
  assign pair_cnt_o = cnt_q;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state and Moore outputs; the pop is qualified by empty
  always_comb begin
    state_nxt    = state;
    fifo_rd_en_o = 1'b0;
    gcd_start_o  = 1'b0;
    res_valid_o  = 1'b0;
    unique case (state)
      IDLE:  state_nxt = RD_A;
      RD_A: begin
        if (!fifo_empty_i) begin
          fifo_rd_en_o = 1'b1;
          state_nxt    = CAP_A;
        end
      end
      CAP_A: state_nxt = RD_B;
      RD_B: begin
        if (!fifo_empty_i) begin
          fifo_rd_en_o = 1'b1;
          state_nxt    = CAP_B;
        end
      end
      CAP_B: state_nxt = bypass ? OUT : START;
      START: begin
        gcd_start_o = 1'b1;
        state_nxt   = WAIT;
      end
      WAIT: begin
        if (gcd_done_i || tmo_hit) state_nxt = OUT;
      end
      OUT: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_nxt = RD_A;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand, result, timeout and hand-off bookkeeping
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state)
        CAP_A: a_q <= fifo_data_i;
        CAP_B: begin
          b_q <= fifo_data_i;
          if (bypass) res_q <= a_q | fifo_data_i;
        end
        START: tmo_cnt <= '0;
        WAIT: begin
          if (gcd_done_i) begin
            res_q <= gcd_result_i;
          end else if (tmo_hit) begin
            tmo_q <= 1'b1;
            res_q <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        OUT: begin
          if (res_ready_i) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
